// File: rtl/net_sched_pkg.sv
// Shared types and helpers for the network TX scheduler.
// Packet type codes, FSM states and requester ids.
package net_sched_pkg;

  localparam logic [3:0] TYPE_BTN = 4'h1;
  localparam logic [3:0] TYPE_DBG = 4'h2;
  localparam logic [3:0] TYPE_HB  = 4'h3;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  typedef enum logic {
    REQ_BTN,
    REQ_DBG
  } req_t;

  // Payload words after the header: value, its complement, then zeros.
  function automatic logic [15:0] tail_word(
    input int          idx,
    input logic [15:0] pay
  );
    logic [15:0] r;
    r = 16'h0000;
    if (idx == 1) r = pay;
    if (idx == 2) r = ~pay;
    return r;
  endfunction

endpackage

// File: rtl/net_tx_scheduler.sv
// Arbitrates button and debug packets into the UDP TX stream,
// emitting fixed bursts separated by a forced idle gap.
module net_tx_scheduler
  import net_sched_pkg::*;
#(
  parameter int DATA_SIZE        = 16,
  parameter int PAYLOAD_WORDS    = 8,
  parameter int GAP_CYCLES       = 2048,
  parameter int HEARTBEAT_CYCLES = 5000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [7:0]           buttons_in,
  input  logic                 dbg_req,
  input  logic [15:0]          dbg_tag,
  output logic                 axiov,
  output logic [DATA_SIZE-1:0] axiod,
  output logic                 busy,
  output logic [11:0]          seq,
  output logic [7:0]           dbg_drops
);

  localparam int WW = $clog2(PAYLOAD_WORDS);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int HW = $clog2(HEARTBEAT_CYCLES + 1);

  state_t         state;
  req_t           last_grant;
  logic           chg_pend;
  logic           hb_flag;
  logic           dbg_pend;
  logic [7:0]     last_btn;
  logic [15:0]    tag_q;
  logic [15:0]    pay;
  logic [HW-1:0]  hb_cnt;
  logic [WW-1:0]  w;
  logic [GW-1:0]  gap_cnt;

  logic           btn_pend;
  logic           hb_hit;
  logic           grant_btn;
  logic           grant_dbg;
  logic [3:0]     typ;

  assign btn_pend = chg_pend | hb_flag;
  assign hb_hit   = (hb_cnt == HW'(HEARTBEAT_CYCLES - 1));

  always_comb begin
    grant_btn = 1'b0;
    grant_dbg = 1'b0;
    if (state == IDLE && en) begin
      if (btn_pend && dbg_pend) begin
        grant_btn = (last_grant == REQ_DBG);
        grant_dbg = (last_grant == REQ_BTN);
      end else begin
        grant_btn = btn_pend;
        grant_dbg = dbg_pend;
      end
    end
  end

  always_comb begin
    typ = TYPE_HB;
    unique case (1'b1)
      grant_dbg: typ = TYPE_DBG;
      chg_pend:  typ = TYPE_BTN;
      default:   typ = TYPE_HB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= REQ_DBG;
      chg_pend   <= 1'b0;
      hb_flag    <= 1'b0;
      dbg_pend   <= 1'b0;
      last_btn   <= '0;
      tag_q      <= '0;
      pay        <= '0;
      hb_cnt     <= '0;
      w          <= '0;
      gap_cnt    <= '0;
      axiov      <= 1'b0;
      axiod      <= '0;
      busy       <= 1'b0;
      seq        <= '0;
      dbg_drops  <= '0;
    end else begin
      if (grant_btn) begin
        chg_pend <= 1'b0;
        hb_flag  <= 1'b0;
        last_btn <= buttons_in;
      end else begin
        if (buttons_in != last_btn) chg_pend <= 1'b1;
        if (hb_hit) hb_flag <= 1'b1;
      end

      if (!en || grant_btn) hb_cnt <= '0;
      else if (!hb_hit) hb_cnt <= hb_cnt + 1'b1;

      // A request landing while one is queued keeps the queued tag.
      if (grant_dbg) dbg_pend <= 1'b0;
      if (dbg_req) begin
        if (dbg_pend) begin
          if (dbg_drops != 8'hFF) dbg_drops <= dbg_drops + 1'b1;
        end else begin
          dbg_pend <= 1'b1;
          tag_q    <= dbg_tag;
        end
      end

      unique case (state)
        IDLE: begin
          if (grant_btn || grant_dbg) begin
            state      <= SEND;
            busy       <= 1'b1;
            axiov      <= 1'b1;
            w          <= '0;
            seq        <= seq + 12'd1;
            last_grant <= grant_btn ? REQ_BTN : REQ_DBG;
            axiod      <= DATA_SIZE'({typ, seq});
            pay        <= grant_btn ? {8'h00, buttons_in} : tag_q;
          end
        end
        SEND: begin
          if (w == WW'(PAYLOAD_WORDS - 1)) begin
            state   <= GAP;
            axiov   <= 1'b0;
            axiod   <= '0;
            gap_cnt <= '0;
          end else begin
            w     <= w + 1'b1;
            axiod <= DATA_SIZE'(tail_word(int'(w) + 1, pay));
          end
        end
        GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_net_tx_scheduler.sv
// Directed self-checking bench for net_tx_scheduler.
// Small gap and heartbeat parameters keep the run short.
module tb_net_tx_scheduler;

  localparam int PW  = 8;
  localparam int GAP = 4;
  localparam int HB  = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b1;
  logic [7:0]  buttons_in = 8'h00;
  logic        dbg_req = 1'b0;
  logic [15:0] dbg_tag = 16'h0000;
  logic        axiov;
  logic [15:0] axiod;
  logic        busy;
  logic [11:0] seq;
  logic [7:0]  dbg_drops;

  int total = 0;
  int bad = 0;

  net_tx_scheduler #(
    .DATA_SIZE(16),
    .PAYLOAD_WORDS(PW),
    .GAP_CYCLES(GAP),
    .HEARTBEAT_CYCLES(HB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .buttons_in(buttons_in),
    .dbg_req(dbg_req),
    .dbg_tag(dbg_tag),
    .axiov(axiov),
    .axiod(axiod),
    .busy(busy),
    .seq(seq),
    .dbg_drops(dbg_drops)
  );

  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) step();
    rst = 1'b1;
  endtask

  task automatic grab(input int limit, output int lat,
                      output logic [PW-1:0][15:0] wds);
    lat = 0;
    wds = '0;
    while (!axiov && lat < limit) begin
      step();
      lat++;
    end
    if (axiov) begin
      for (int i = 0; i < PW; i++) begin
        wds[i] = axiod;
        step();
      end
    end else begin
      lat = -1;
    end
  endtask

  task automatic test_reset();
    int lat;
    logic [PW-1:0][15:0] wd;
    buttons_in = 8'h00;
    do_reset(3);
    total++;
    if ({axiov, busy, axiod} !== 18'h0) begin
      bad++; $display("FAIL reset_out got=%h want=0", {axiov, busy, axiod});
    end
    total++;
    if (seq !== 12'h000) begin
      bad++; $display("FAIL reset_seq got=%h want=000", seq);
    end
    total++;
    if (dbg_drops !== 8'h00) begin
      bad++; $display("FAIL reset_drops got=%h want=00", dbg_drops);
    end
    buttons_in = 8'h41;
    step();
    step();
    step();
    rst = 1'b0;
    step();
    total++;
    if ({axiov, busy, seq, dbg_drops} !== 22'h0) begin
      bad++;
      $display("FAIL midburst_reset got=%h want=0",
               {axiov, busy, seq, dbg_drops});
    end
    repeat (4) step();
    rst = 1'b1;
    grab(20, lat, wd);
    total++;
    if (lat !== 2) begin
      bad++; $display("FAIL reset_nogap_lat got=%0d want=2", lat);
    end
    total++;
    if (wd[0] !== 16'h1000) begin
      bad++; $display("FAIL reset_w0 got=%h want=1000", wd[0]);
    end
  endtask

  task automatic test_button();
    int lat;
    int g;
    logic [PW-1:0][15:0] wd;
    logic [PW-1:0][15:0] ex;
    buttons_in = 8'h00;
    do_reset(2);
    buttons_in = 8'h41;
    grab(10, lat, wd);
    total++;
    if (lat !== 2) begin
      bad++; $display("FAIL btn_lat got=%0d want=2", lat);
    end
    ex = '0;
    ex[0] = 16'h1000;
    ex[1] = 16'h0041;
    ex[2] = 16'hFFBE;
    for (int i = 0; i < PW; i++) begin
      total++;
      if (wd[i] !== ex[i]) begin
        bad++; $display("FAIL btn_word%0d got=%h want=%h", i, wd[i], ex[i]);
      end
    end
    total++;
    if ({busy, seq} !== {1'b1, 12'h001}) begin
      bad++; $display("FAIL btn_gap_state got=%h want=1001", {busy, seq});
    end
    buttons_in = 8'h42;
    g = 0;
    while (!axiov && g < 100) begin
      step();
      g++;
    end
    total++;
    if (g < GAP || g > GAP + 1) begin
      bad++; $display("FAIL btn_gap_len got=%0d want=%0d..%0d", g, GAP, GAP + 1);
    end
    grab(0, lat, wd);
    total++;
    if ({wd[0], wd[1], wd[2]} !== {16'h1001, 16'h0042, 16'hFFBD}) begin
      bad++;
      $display("FAIL btn_second got=%h want=10010042ffbd", {wd[0], wd[1], wd[2]});
    end
    repeat (GAP) step();
    total++;
    if ({busy, seq} !== {1'b0, 12'h002}) begin
      bad++; $display("FAIL btn_idle got=%h want=0002", {busy, seq});
    end
  endtask

  task automatic test_simultaneous();
    int lat;
    logic [PW-1:0][15:0] wd;
    buttons_in = 8'h00;
    do_reset(2);
    buttons_in = 8'h41;
    dbg_req = 1'b1;
    dbg_tag = 16'hABCD;
    step();
    dbg_req = 1'b0;
    grab(10, lat, wd);
    total++;
    if ({wd[0], wd[1]} !== {16'h1000, 16'h0041} || lat !== 1) begin
      bad++;
      $display("FAIL simul_first got=%h lat=%0d want=10000041 lat=1",
               {wd[0], wd[1]}, lat);
    end
    grab(20, lat, wd);
    total++;
    if ({wd[0], wd[1], wd[2], wd[3]} !==
        {16'h2001, 16'hABCD, 16'h5432, 16'h0000}) begin
      bad++;
      $display("FAIL simul_dbg got=%h want=2001abcd54320000",
               {wd[0], wd[1], wd[2], wd[3]});
    end
    total++;
    if (dbg_drops !== 8'h00) begin
      bad++; $display("FAIL simul_drops got=%h want=00", dbg_drops);
    end
  endtask

  task automatic test_drop();
    int lat;
    logic [PW-1:0][15:0] wd;
    buttons_in = 8'h00;
    do_reset(2);
    dbg_req = 1'b1;
    dbg_tag = 16'h1111;
    step();
    dbg_tag = 16'h2222;
    step();
    dbg_req = 1'b0;
    total++;
    if (dbg_drops !== 8'h01) begin
      bad++; $display("FAIL drop_count got=%h want=01", dbg_drops);
    end
    grab(5, lat, wd);
    total++;
    if ({wd[0], wd[1], wd[2]} !== {16'h2000, 16'h1111, 16'hEEEE}) begin
      bad++;
      $display("FAIL drop_tag got=%h want=20001111eeee", {wd[0], wd[1], wd[2]});
    end
    dbg_req = 1'b1;
    dbg_tag = 16'h3333;
    step();
    dbg_req = 1'b0;
    grab(20, lat, wd);
    total++;
    if ({wd[0], wd[1], wd[2], dbg_drops} !==
        {16'h2001, 16'h3333, 16'hCCCC, 8'h01}) begin
      bad++;
      $display("FAIL drop_gapreq got=%h want=20013333cccc01",
               {wd[0], wd[1], wd[2], dbg_drops});
    end
    dbg_req = 1'b1;
    dbg_tag = 16'h4444;
    repeat (400) step();
    dbg_req = 1'b0;
    total++;
    if (dbg_drops !== 8'hFF) begin
      bad++; $display("FAIL drop_saturate got=%h want=ff", dbg_drops);
    end
  endtask

  task automatic test_heartbeat();
    int lat;
    logic [PW-1:0][15:0] wd;
    buttons_in = 8'h00;
    do_reset(2);
    grab(200, lat, wd);
    total++;
    if (lat !== HB + 1) begin
      bad++; $display("FAIL hb_first_lat got=%0d want=%0d", lat, HB + 1);
    end
    total++;
    if ({wd[0], wd[1], wd[2]} !== {16'h3000, 16'h0000, 16'hFFFF}) begin
      bad++;
      $display("FAIL hb_first got=%h want=30000000ffff", {wd[0], wd[1], wd[2]});
    end
    grab(200, lat, wd);
    total++;
    if (lat !== HB + 1 - PW || wd[0] !== 16'h3001) begin
      bad++;
      $display("FAIL hb_second got=%h lat=%0d want=3001 lat=%0d",
               wd[0], lat, HB + 1 - PW);
    end
  endtask

  task automatic test_enable();
    int lat;
    int v;
    logic [PW-1:0][15:0] wd;
    buttons_in = 8'h00;
    en = 1'b1;
    do_reset(2);
    buttons_in = 8'h41;
    repeat (4) step();
    en = 1'b0;
    v = 0;
    while (axiov && v < 20) begin
      v++;
      step();
    end
    total++;
    if (v !== PW - 2) begin
      bad++; $display("FAIL en_burst_finish got=%0d want=%0d", v, PW - 2);
    end
    buttons_in = 8'h42;
    v = 0;
    for (int i = 0; i < 200; i++) begin
      if (axiov) v++;
      step();
    end
    total++;
    if ({v[7:0], busy, seq} !== {8'd0, 1'b0, 12'h001}) begin
      bad++;
      $display("FAIL en_hold got=%0d busy=%b seq=%h want=0 busy=0 seq=001",
               v, busy, seq);
    end
    en = 1'b1;
    grab(10, lat, wd);
    total++;
    if (lat !== 1 || {wd[0], wd[1]} !== {16'h1001, 16'h0042}) begin
      bad++;
      $display("FAIL en_resume got=%h lat=%0d want=10010042 lat=1",
               {wd[0], wd[1]}, lat);
    end
  endtask

  task automatic test_wrap();
    int n;
    logic prev;
    logic [15:0] w_last;
    logic [15:0] w_wrap;
    logic [11:0] seq_after;
    n = 0;
    prev = 1'b0;
    w_last = '0;
    w_wrap = '0;
    seq_after = 12'hABC;
    buttons_in = 8'h55;
    do_reset(2);
    for (int cyc = 0; cyc < 62000 && n < 4097; cyc++) begin
      buttons_in = ~buttons_in;
      step();
      if (axiov && !prev) begin
        n++;
        if (n == 4096) begin
          w_last = axiod;
          seq_after = seq;
        end
        if (n == 4097) w_wrap = axiod;
      end
      prev = axiov;
    end
    total++;
    if (n !== 4097) begin
      bad++; $display("FAIL wrap_count got=%0d want=4097", n);
    end
    total++;
    if ({w_last, seq_after} !== {16'h1FFF, 12'h000}) begin
      bad++; $display("FAIL wrap_last got=%h want=1fff000", {w_last, seq_after});
    end
    total++;
    if (w_wrap !== 16'h1000) begin
      bad++; $display("FAIL wrap_first got=%h want=1000", w_wrap);
    end
  endtask

  initial begin
    test_reset();
    test_button();
    test_simultaneous();
    test_drop();
    test_heartbeat();
    test_enable();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
